lc3_control: RTL and testbench
==============================

LC3_CONTROL -- requirements
Module: lc3_control

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port run, input, 1 bit: level; enables instruction sequencing.
REQ-004 The module SHALL have port mem_rdata, input, 16 bits: memory read data.
REQ-005 The module SHALL have port mem_valid, input, 1 bit: one-cycle strobe; mem_rdata is valid.
REQ-006 The module SHALL have port fetch_start, output, 1 bit: one-cycle pulse that launches the fetch unit.
REQ-007 The module SHALL have port ir, output, 16 bits: latched instruction register.
REQ-008 The module SHALL have port opcode, output, 4 bits: equal to ir[15:12].
REQ-009 The module SHALL have ports decode_en, exec_en, mem_en and wb_en, each output, 1 bit: stage enables.
REQ-010 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE and HALT.
REQ-011 The module SHALL have port halted, output, 1 bit: sticky halt flag.
REQ-012 The module SHALL have port err, output, 1 bit: sticky error flag, valid while halted.
REQ-013 The module SHALL have port instr_count, output, 16 bits: count of retired instructions.

Function
REQ-014 The module SHALL implement an FSM with states IDLE, FETCH, WAIT_I, DECODE, EXEC, MEM, MEM2, WB and HALT.
REQ-015 In IDLE with run=1, the FSM SHALL move to FETCH, and fetch_start SHALL be 1 for exactly the single FETCH cycle.
REQ-016 FETCH SHALL move to WAIT_I unconditionally.
REQ-017 In WAIT_I, ir SHALL load mem_rdata on the first cycle with mem_valid=1, and the FSM SHALL then move to DECODE.
REQ-018 WAIT_I SHALL time out: if 16 cycles pass without mem_valid, the FSM SHALL go to HALT with err=1.
REQ-019 DECODE SHALL assert decode_en for 1 cycle, then go to EXEC; except opcode 1101 (reserved), which SHALL go to HALT with err=1.
REQ-020 EXEC SHALL assert exec_en for 1 cycle.
REQ-021 From EXEC, TRAP with ir[7:0]=8'h25 SHALL go to HALT with err=0.
REQ-022 From EXEC, memory ops (LD, ST, LDR, STR, LDI, STI) SHALL go to MEM.
REQ-023 From EXEC, writeback ops without memory access (ADD, AND, NOT, LEA) SHALL go to WB.
REQ-024 From EXEC, all other ops (BR, JMP, JSR, RTI, other TRAP) SHALL retire.
REQ-025 MEM and MEM2 SHALL hold mem_en=1 until mem_valid, under the same 16-cycle timeout as WAIT_I.
REQ-026 LDI and STI SHALL pass MEM then MEM2; the other memory ops SHALL use MEM only.
REQ-027 After the memory access completes, LD, LDR and LDI SHALL go to WB; ST, STR and STI SHALL retire.
REQ-028 WB SHALL assert wb_en for 1 cycle, then retire.
REQ-029 Retire SHALL increment instr_count modulo 2^16 (16'hFFFF wraps to 0) and go to FETCH if run=1, else IDLE.
REQ-030 Clearing run mid-instruction SHALL NOT abort the instruction; the FSM SHALL finish it and retire to IDLE.
REQ-031 At most one of fetch_start, decode_en, exec_en, mem_en and wb_en SHALL be high in any cycle.
REQ-032 HALT SHALL be terminal until rst: all enables 0, busy=0, halted=1, ir held.
REQ-033 mem_valid arriving in any state other than WAIT_I, MEM or MEM2 SHALL be ignored.

Reset
REQ-034 On rst=1, the FSM SHALL go to IDLE immediately, regardless of clk.
REQ-035 On rst=1, ir, instr_count and the timeout counter SHALL be 0.
REQ-036 On rst=1, all enables, busy, halted and err SHALL be 0.
REQ-037 Reset asserted mid-instruction SHALL discard that instruction; it SHALL NOT be counted.

Structure
REQ-038 Package lc3_pkg SHALL hold the 16 opcode constants, the state enumeration, TRAP_HALT=8'h25 and TIMEOUT=16.
REQ-039 A combinational sub-module lc3_op_class SHALL map opcode to is_mem, is_double and is_wb.
REQ-040 The FSM, ir register, timeout counter and retire counter SHALL reside in lc3_control.

Verification
REQ-041 Scenario: run=1, mem_valid 2 cycles after fetch_start with 16'h1261 (ADD) -> DECODE, EXEC and WB each pulse once, then instr_count=1 and fetch_start fires again.
REQ-042 Scenario: 16'hA402 (LDI) with two timely mem_valid strobes -> mem_en high across MEM and MEM2, then wb_en=1, instr_count=1.
REQ-043 Scenario: 16'hF025 (TRAP x25) -> halted=1, err=0, busy=0; run stays 1 for 20 more cycles -> no fetch_start.
REQ-044 Scenario: no mem_valid after fetch_start -> halted=1, err=1 on cycle 16 of WAIT_I; opcode 1101 -> halted=1, err=1 after DECODE.
REQ-045 Scenario: run dropped during EXEC of 16'h3001 (ST) -> mem_en until mem_valid, then IDLE with instr_count incremented.
REQ-046 Scenario: rst pulsed mid-MEM -> all outputs 0 with no clock edge; instr_count preset to 16'hFFFF via stimulus wraps to 0 on retire.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared constants and types for the LC-3 instruction sequencer.
// Holds the opcode encodings, the FSM state enumeration and the timing limits.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [7:0] TRAP_HALT = 8'h25;
    localparam int         TIMEOUT   = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_I,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MEM2,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/lc3_control_op_class.sv
// Opcode classifier: memory access, double (indirect) access and register writeback.
module lc3_op_class
    import lc3_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_mem_o,
    output logic       is_double_o,
    output logic       is_wb_o
);

    always_comb begin
        is_mem_o    = 1'b0;
        is_double_o = 1'b0;
        is_wb_o     = 1'b0;
        case (opcode_i)
            OP_LD, OP_LDR: begin
                is_mem_o = 1'b1;
                is_wb_o  = 1'b1;
            end
            OP_ST, OP_STR: begin
                is_mem_o = 1'b1;
            end
            OP_LDI: begin
                is_mem_o    = 1'b1;
                is_double_o = 1'b1;
                is_wb_o     = 1'b1;
            end
            OP_STI: begin
                is_mem_o    = 1'b1;
                is_double_o = 1'b1;
            end
            OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
                is_wb_o = 1'b1;
            end
            default: begin
                is_mem_o    = 1'b0;
                is_double_o = 1'b0;
                is_wb_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_control.sv
// LC-3 instruction sequencer: fetch/decode/exec/mem/wb stepping with timeouts,
// halt handling and a retired-instruction counter.
module lc3_control
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        fetch_start,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [15:0] instr_count,
    output state_t      dbg_state_o
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [15:0] instr_count_q;
    wire  [15:0] instr_count_d;
    logic        retire;
    logic        tmo_expired;
    logic        is_mem, is_double, is_wb;

    lc3_op_class u_op_class (
        .opcode_i    (ir_q[15:12]),
        .is_mem_o    (is_mem),
        .is_double_o (is_double),
        .is_wb_o     (is_wb)
    );

    // Timeout fires on the last allowed wait cycle when mem_valid is still absent.
    assign tmo_expired   = (tmo_q == 5'(TIMEOUT - 1));
    assign instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        tmo_d   = '0;
        err_d   = err_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT_I;
            S_WAIT_I: begin
                if (mem_valid) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            S_DECODE: begin
                if (ir_q[15:12] == OP_RES) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ir_q[15:12] == OP_TRAP && ir_q[7:0] == TRAP_HALT) state_d = S_HALT;
                else if (is_mem) state_d = S_MEM;
                else if (is_wb)  state_d = S_WB;
                else             retire  = 1'b1;
            end
            S_MEM, S_MEM2: begin
                if (mem_valid) begin
                    if (state_q == S_MEM && is_double) state_d = S_MEM2;
                    else if (is_wb)                    state_d = S_WB;
                    else                               retire  = 1'b1;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            S_WB:    retire = 1'b1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // A cleared run only takes effect at the instruction boundary.
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ir_q          <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign fetch_start = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXEC);
    assign mem_en      = (state_q == S_MEM) || (state_q == S_MEM2);
    assign wb_en       = (state_q == S_WB);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign err         = err_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[15:12];
    assign instr_count = instr_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: hand-computed vectors checked with immediate assertions.
module tb_lc3_control;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        fetch_start, decode_en, exec_en, mem_en, wb_en, busy, halted, err;
    logic [15:0] ir, instr_count;
    logic [3:0]  opcode;
    state_t      dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    // Control vector order: {fetch_start, decode_en, exec_en, mem_en, wb_en, busy, halted, err}
    localparam logic [7:0] C_ZERO  = 8'b0000_0000;
    localparam logic [7:0] C_FETCH = 8'b1000_0100;
    localparam logic [7:0] C_WAIT  = 8'b0000_0100;
    localparam logic [7:0] C_DEC   = 8'b0100_0100;
    localparam logic [7:0] C_EXEC  = 8'b0010_0100;
    localparam logic [7:0] C_MEM   = 8'b0001_0100;
    localparam logic [7:0] C_WB    = 8'b0000_1100;
    localparam logic [7:0] C_HALT  = 8'b0000_0010;
    localparam logic [7:0] C_HERR  = 8'b0000_0011;

    always #5 clk = ~clk;

    lc3_control dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .fetch_start (fetch_start),
        .ir          (ir),
        .opcode      (opcode),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count),
        .dbg_state_o (dbg_state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk(tag, {8'h00, fetch_start, decode_en, exec_en, mem_en, wb_en, busy, halted, err},
            {8'h00, exp});
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk(tag, {12'h000, dbg_state}, {12'h000, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_ctl("reset_ctl", C_ZERO);
        chk("reset_ir", ir, 16'h0000);
        chk("reset_cnt", instr_count, 16'h0000);
        chk_state("reset_state", S_IDLE);

        // ADD 16'h1261, strobe two cycles after fetch_start
        run = 1'b1;
        tick(); chk_ctl("add_fetch", C_FETCH);
        tick(); chk_ctl("add_wait1", C_WAIT);
        tick(); chk_ctl("add_wait2", C_WAIT);
        mem_valid = 1'b1; mem_rdata = 16'h1261;
        tick(); chk_ctl("add_decode", C_DEC);
        chk("add_ir", ir, 16'h1261);
        chk("add_opcode", {12'h000, opcode}, 16'h0001);
        mem_valid = 1'b0;
        tick(); chk_ctl("add_exec", C_EXEC);
        tick(); chk_ctl("add_wb", C_WB);
        tick(); chk_ctl("add_refetch", C_FETCH);
        chk("add_cnt", instr_count, 16'h0001);

        // LDI 16'hA402: MEM then MEM2, then WB; run dropped in WB retires to IDLE
        do_reset();
        run = 1'b1;
        tick(); chk_ctl("ldi_fetch", C_FETCH);
        tick(); chk_ctl("ldi_wait", C_WAIT);
        mem_valid = 1'b1; mem_rdata = 16'hA402;
        tick(); chk_ctl("ldi_decode", C_DEC);
        mem_valid = 1'b0;
        tick(); chk_ctl("ldi_exec", C_EXEC);
        tick(); chk_ctl("ldi_mem", C_MEM);
        chk_state("ldi_mem_state", S_MEM);
        tick(); chk_ctl("ldi_mem_hold", C_MEM);
        mem_valid = 1'b1;
        tick(); chk_ctl("ldi_mem2", C_MEM);
        chk_state("ldi_mem2_state", S_MEM2);
        tick(); chk_ctl("ldi_wb", C_WB);
        mem_valid = 1'b0; run = 1'b0;
        tick(); chk_ctl("ldi_idle", C_ZERO);
        chk("ldi_cnt", instr_count, 16'h0001);

        // TRAP x25 halts cleanly; strobe during FETCH is ignored
        do_reset();
        run = 1'b1;
        tick(); chk_ctl("trap_fetch", C_FETCH);
        mem_valid = 1'b1; mem_rdata = 16'h1111;
        tick(); chk("trap_ignore_ir", ir, 16'h0000);
        mem_rdata = 16'hF025;
        tick(); chk("trap_ir", ir, 16'hF025);
        mem_valid = 1'b0;
        tick(); chk_ctl("trap_exec", C_EXEC);
        tick(); chk_ctl("trap_halt", C_HALT);
        for (int i = 0; i < 20; i++) begin
            mem_valid = i[0];
            mem_rdata = 16'h1234;
            tick(); chk_ctl("trap_halt_hold", C_HALT);
        end
        mem_valid = 1'b0;
        chk("trap_ir_held", ir, 16'hF025);
        chk("trap_cnt", instr_count, 16'h0000);

        // Fetch timeout: halt decided on WAIT_I cycle 16
        do_reset();
        run = 1'b1;
        tick(); chk_ctl("tmo_fetch", C_FETCH);
        tick(); chk_ctl("tmo_wait_first", C_WAIT);
        for (int i = 2; i <= 16; i++) begin
            tick(); chk_ctl("tmo_wait_busy", C_WAIT);
        end
        tick(); chk_ctl("tmo_halt_err", C_HERR);

        // Reserved opcode 1101 halts with error after DECODE
        do_reset();
        chk_ctl("res_reset_clears_err", C_ZERO);
        run = 1'b1;
        tick(); tick();
        mem_valid = 1'b1; mem_rdata = 16'hD000;
        tick(); chk_ctl("res_decode", C_DEC);
        mem_valid = 1'b0;
        tick(); chk_ctl("res_halt_err", C_HERR);

        // ST 16'h3001 with run dropped in EXEC finishes and idles
        do_reset();
        run = 1'b1;
        tick(); tick();
        mem_valid = 1'b1; mem_rdata = 16'h3001;
        tick(); mem_valid = 1'b0;
        tick(); chk_ctl("st_exec", C_EXEC);
        run = 1'b0;
        tick(); chk_ctl("st_mem", C_MEM);
        tick(); tick(); chk_ctl("st_mem_hold", C_MEM);
        mem_valid = 1'b1;
        tick(); chk_ctl("st_idle", C_ZERO);
        chk_state("st_idle_state", S_IDLE);
        chk("st_cnt", instr_count, 16'h0001);
        mem_valid = 1'b0;
        tick(); chk_ctl("st_stay_idle", C_ZERO);

        // LD 16'h2000 then asynchronous reset in MEM, between clock edges
        run = 1'b1;
        tick(); tick();
        mem_valid = 1'b1; mem_rdata = 16'h2000;
        tick(); mem_valid = 1'b0;
        tick(); tick(); chk_ctl("rst_mem", C_MEM);
        #2 rst = 1'b1;
        #1;
        chk_ctl("rst_async_ctl", C_ZERO);
        chk("rst_async_ir", ir, 16'h0000);
        chk("rst_async_cnt", instr_count, 16'h0000);
        chk_state("rst_async_state", S_IDLE);
        tick();
        rst = 1'b0; run = 1'b0;

        // Counter wrap: preset to FFFF, retire a BR
        force dut.instr_count_d = 16'hFFFF;
        tick();
        release dut.instr_count_d;
        chk("wrap_preset", instr_count, 16'hFFFF);
        run = 1'b1;
        tick(); tick();
        mem_valid = 1'b1; mem_rdata = 16'h0E05;
        tick(); mem_valid = 1'b0;
        tick(); chk_ctl("wrap_exec", C_EXEC);
        run = 1'b0;
        tick(); chk("wrap_cnt", instr_count, 16'h0000);
        chk_ctl("wrap_idle", C_ZERO);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
